// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// Bundles the three buses around the RAM port arbiter:
//   - instruction fetch requester (read-only):  i_addr, i_ren -> i_rdata, i_busy
//   - data requester (read/write):               d_addr, d_wdata, d_byte_en, d_ren, d_wen
//                                                -> d_rdata, d_busy
//   - single-port latency RAM:                   ram_addr, ram_wdata, ram_byte_en, ram_ren,
//                                                ram_wen -> ram_rdata, ram_busy
// Modports:
//   slave  - the arbiter's view (serves both requesters, drives the RAM inputs)
//   master - the surrounding environment (requesters and RAM model)
// Parameters: ADDR_BITS word-address width, N_BYTES bytes per data word.
interface ram_port_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int N_BYTES   = 4
);
    localparam int N_BITS = N_BYTES * 8;

    logic [ADDR_BITS-1:0] i_addr;
    logic                 i_ren;
    logic [N_BITS-1:0]    i_rdata;
    logic                 i_busy;

    logic [ADDR_BITS-1:0] d_addr;
    logic [N_BITS-1:0]    d_wdata;
    logic [N_BYTES-1:0]   d_byte_en;
    logic                 d_ren;
    logic                 d_wen;
    logic [N_BITS-1:0]    d_rdata;
    logic                 d_busy;

    logic [ADDR_BITS-1:0] ram_addr;
    logic [N_BITS-1:0]    ram_wdata;
    logic [N_BYTES-1:0]   ram_byte_en;
    logic                 ram_ren;
    logic                 ram_wen;
    logic [N_BITS-1:0]    ram_rdata;
    logic                 ram_busy;

    modport slave (
        input  i_addr, i_ren,
        output i_rdata, i_busy,
        input  d_addr, d_wdata, d_byte_en, d_ren, d_wen,
        output d_rdata, d_busy,
        output ram_addr, ram_wdata, ram_byte_en, ram_ren, ram_wen,
        input  ram_rdata, ram_busy
    );

    modport master (
        output i_addr, i_ren,
        input  i_rdata, i_busy,
        output d_addr, d_wdata, d_byte_en, d_ren, d_wen,
        input  d_rdata, d_busy,
        input  ram_addr, ram_wdata, ram_byte_en, ram_ren, ram_wen,
        output ram_rdata, ram_busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port latency RAM between an instruction fetch requester (I, read-only)
// and a data requester (D, read/write). A grant is held for the whole transaction because
// the RAM restarts its latency count whenever its inputs change; the RAM inputs are driven
// combinationally from the granted requester, which must keep its request stable while busy.
// Ports:
//   CLK   - clock, all state on posedge
//   nRST  - asynchronous active-low reset (IDLE, no grant, last grant = I)
//   bus   - ram_port_arbiter_if.slave: I bus, D bus and RAM bus
// Configuration macro ROUND_ROBIN_EN:
//   defined   - simultaneous requests in IDLE go to the requester not granted last
//   undefined - simultaneous requests in IDLE always go to D (I may starve)
module ram_port_arbiter (
    input  logic              CLK,
    input  logic              nRST,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

    state_t r_state;
    state_t w_next;
    logic   w_i_req;
    logic   w_d_req;
    logic   w_pick_d;   // tie-break when both request in IDLE

    assign w_i_req = bus.i_ren;
    assign w_d_req = bus.d_ren | bus.d_wen;

`ifdef ROUND_ROBIN_EN
    logic r_last_d;     // 1 = D completed last, 0 = I completed last
    logic w_done_i;
    logic w_done_d;

    assign w_done_i = (r_state == GNT_I) && w_i_req && !bus.ram_busy;
    assign w_done_d = (r_state == GNT_D) && w_d_req && !bus.ram_busy;
    assign w_pick_d = !r_last_d;

    // Only completed transactions move the round-robin pointer; aborts leave it alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)         r_last_d <= 1'b0;
        else if (w_done_d) r_last_d <= 1'b1;
        else if (w_done_i) r_last_d <= 1'b0;
    end
`else
    assign w_pick_d = 1'b1;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        bus.ram_addr    = '0;
        bus.ram_wdata   = '0;
        bus.ram_byte_en = '0;
        bus.ram_ren     = 1'b0;
        bus.ram_wen     = 1'b0;
        bus.i_busy      = 1'b1;
        bus.i_rdata     = '0;
        bus.d_busy      = 1'b1;
        bus.d_rdata     = '0;

        case (r_state)
            IDLE: begin
                if (w_d_req && (!w_i_req || w_pick_d)) w_next = GNT_D;
                else if (w_i_req)                      w_next = GNT_I;
            end

            GNT_I: begin
                // A dropped request aborts: RAM sees nothing this cycle, no completion.
                if (!w_i_req) begin
                    w_next = IDLE;
                end else begin
                    bus.ram_addr = bus.i_addr;
                    bus.ram_ren  = 1'b1;
                    if (!bus.ram_busy) begin
                        bus.i_busy  = 1'b0;
                        bus.i_rdata = bus.ram_rdata;
                        w_next      = IDLE;
                    end
                end
            end

            GNT_D: begin
                if (!w_d_req) begin
                    w_next = IDLE;
                end else begin
                    bus.ram_addr    = bus.d_addr;
                    bus.ram_wdata   = bus.d_wdata;
                    bus.ram_byte_en = bus.d_byte_en;
                    // ren together with wen is treated as a plain write.
                    bus.ram_ren     = bus.d_ren & ~bus.d_wen;
                    bus.ram_wen     = bus.d_wen;
                    if (!bus.ram_busy) begin
                        bus.d_busy  = 1'b0;
                        bus.d_rdata = bus.ram_rdata;
                        w_next      = IDLE;
                    end
                end
            end

            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Randomized and directed stimulus against ram_port_arbiter with a latency-RAM model.
// Expectations come from a transaction-level model: arbitration order, completion cycle
// (request cycle + 1 + LAT, next requester after one IDLE turnaround) and a shadow memory.
module tb_ram_port_arbiter;
    localparam int AB = 16;
    localparam int NB = 4;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ram_port_arbiter_if #(.ADDR_BITS(AB), .N_BYTES(NB)) bus ();

    ram_port_arbiter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- latency RAM model ----------------
    int          lat = 0;
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        load_mem = 1'b0;
    logic [53:0] ram_sig;
    logic [53:0] ram_prev_sig = '0;
    logic        ram_prev_act = 1'b0;
    int          ram_cnt = 0;
    int          ram_cur_cnt;
    logic        ram_act;

    always_comb begin
        ram_act       = bus.ram_ren | bus.ram_wen;
        ram_sig       = {bus.ram_ren, bus.ram_wen, bus.ram_byte_en, bus.ram_addr, bus.ram_wdata};
        ram_cur_cnt   = (ram_prev_act && ram_sig == ram_prev_sig) ? ram_cnt : 0;
        bus.ram_busy  = ram_act && (ram_cur_cnt < lat);
        bus.ram_rdata = mem[bus.ram_addr[7:0]];
    end

    always @(posedge CLK) begin
        if (load_mem) begin
            for (int a = 0; a < 256; a++) mem[a] <= ref_mem[a];
        end else if (ram_act && !bus.ram_busy) begin
            if (bus.ram_wen)
                for (int b = 0; b < 4; b++)
                    if (bus.ram_byte_en[b])
                        mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            ram_prev_act <= 1'b0;
            ram_cnt      <= 0;
        end else begin
            ram_prev_act <= ram_act;
            ram_prev_sig <= ram_sig;
            ram_cnt      <= ram_cur_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    bit          m_last_d = 1'b0;   // model: D completed last
    logic [31:0] last_i_rdata;
    logic [31:0] last_d_rdata;

    task automatic clear_reqs();
        bus.i_addr = '0; bus.i_ren = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_byte_en = '0;
        bus.d_ren = 1'b0; bus.d_wen = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_i_busy"}, bus.i_busy, 1'b1);
        chk({tag, "_d_busy"}, bus.d_busy, 1'b1);
        chk({tag, "_ram_ren"}, bus.ram_ren, 1'b0);
        chk({tag, "_ram_wen"}, bus.ram_wen, 1'b0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 16'h0);
        chk({tag, "_i_rdata"}, bus.i_rdata, 32'h0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    endtask

    // One round: I and/or D issue a request in the same IDLE cycle; each holds it until done.
    task automatic run_round(input bit ui, input bit ud, input bit dw, input bit dr,
                             input logic [7:0] ia, input logic [7:0] da,
                             input logic [31:0] wd, input logic [3:0] be, input int l);
        bit          first_d;
        int          t0, ti, td, t_first, t_second, exp_ti, exp_td, ic, dc;
        logic [31:0] ig, dg, exp_i, exp_d;
        ic = 0; dc = 0; ti = 0; td = 0; ig = '0; dg = '0;
        exp_i = '0; exp_d = '0; exp_ti = 0; exp_td = 0;
        lat = l;
        @(posedge CLK); #1;
        bus.i_addr = {8'h00, ia}; bus.i_ren = ui;
        bus.d_addr = {8'h00, da}; bus.d_wdata = wd; bus.d_byte_en = be;
        bus.d_ren  = ud & dr;     bus.d_wen = ud & dw;
        t0 = cyc;
        for (int k = 0; k < 8 * l + 16; k++) begin
            @(negedge CLK);
            if (!bus.i_busy) begin ic++; ti = cyc; ig = bus.i_rdata; end
            if (!bus.d_busy) begin dc++; td = cyc; dg = bus.d_rdata; end
            if ((ic > 0 || !ui) && (dc > 0 || !ud)) break;
            @(posedge CLK); #1;
            if (ic > 0) bus.i_ren = 1'b0;
            if (dc > 0) begin bus.d_ren = 1'b0; bus.d_wen = 1'b0; end
        end

        // Model: winner by arbitration rule, loser after one IDLE turnaround.
        first_d  = (ui && ud) ? (RR ? !m_last_d : 1'b1) : ud;
        t_first  = t0 + 1 + l;
        t_second = t_first + 2 + l;
        if (ud && first_d) begin
            exp_td = t_first;
            if (dw) begin
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[da][8*b +: 8] = wd[8*b +: 8];
            end else exp_d = ref_mem[da];
        end
        if (ui) begin
            exp_ti = first_d ? t_second : t_first;
            exp_i  = ref_mem[ia];
        end
        if (ud && !first_d) begin
            exp_td = t_second;
            if (dw) begin
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[da][8*b +: 8] = wd[8*b +: 8];
            end else exp_d = ref_mem[da];
        end
        m_last_d = (ui && ud) ? !first_d : ud;

        chk("i_count", ic, ui);
        chk("d_count", dc, ud);
        if (ui) begin
            chk("i_cycle", ti - t0, exp_ti - t0);
            chk("i_rdata", ig, exp_i);
        end
        if (ud) begin
            chk("d_cycle", td - t0, exp_td - t0);
            if (!dw) chk("d_rdata", dg, exp_d);
        end
        last_i_rdata = ig;
        last_d_rdata = dg;

        @(posedge CLK); #1;
        clear_reqs();
        @(negedge CLK);
        check_idle("turnaround");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit          ui, ud, dw, dr;
        int          op, n, t0, ic, dz, ti;
        logic [7:0]  ord, exp_ord;
        logic [31:0] ig;
        bit          e_last, pick;

        clear_reqs();
        for (int a = 0; a < 256; a++) ref_mem[a] = $urandom;
        ref_mem[8'h10] = 32'hDEADBEEF;
        ref_mem[8'h20] = 32'hAABBCCDD;
        ref_mem[8'h40] = 32'h55AA55AA;
        load_mem = 1'b1;
        lat = 0;
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 load_mem = 1'b0;
        @(negedge CLK);
        check_idle("in_reset");
        @(posedge CLK); #1 nRST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check_idle("post_reset");
        end

        // I read, LAT=2
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 32'h0, 4'h0, 2);
        chk("i_read_deadbeef", last_i_rdata, 32'hDEADBEEF);

        // D partial write then D read back
        run_round(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 32'h11223344, 4'b0011, 1);
        run_round(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h20, 32'h0, 4'h0, 1);
        chk("byte_merge", last_d_rdata, 32'hAABB3344);

        // Continuous dual requests, LAT=1: 8 grants
        lat = 1;
        @(posedge CLK); #1;
        bus.i_addr = 16'h0011; bus.i_ren = 1'b1;
        bus.d_addr = 16'h0021; bus.d_ren = 1'b1;
        exp_ord = '0; e_last = m_last_d;
        for (int k = 0; k < 8; k++) begin
            pick    = RR ? !e_last : 1'b1;
            exp_ord = {exp_ord[6:0], pick};
            e_last  = pick;
        end
        ord = '0; n = 0;
        for (int k = 0; k < 80 && n < 8; k++) begin
            @(negedge CLK);
            if (!bus.d_busy || !bus.i_busy)
                chk("cont_single_done", !bus.d_busy && !bus.i_busy, 1'b0);
            if (!bus.d_busy) begin
                ord = {ord[6:0], 1'b1}; n++;
                chk("cont_d_rdata", bus.d_rdata, ref_mem[8'h21]);
            end else if (!bus.i_busy) begin
                ord = {ord[6:0], 1'b0}; n++;
                chk("cont_i_rdata", bus.i_rdata, ref_mem[8'h11]);
            end
        end
        chk("cont_grants", n, 8);
        chk("cont_order", ord, exp_ord);
        m_last_d = e_last;
        @(posedge CLK); #1;
        clear_reqs();
        @(negedge CLK);
        check_idle("cont_end");

        // D abort with I pending, LAT=3
        lat = 3;
        @(posedge CLK); #1;
        bus.d_addr = 16'h0030; bus.d_ren = 1'b1;
        t0 = cyc;
        @(negedge CLK);
        @(posedge CLK); #1;
        bus.i_addr = 16'h0031; bus.i_ren = 1'b1;
        @(negedge CLK);
        chk("abort_gnt_ren", bus.ram_ren, 1'b1);
        chk("abort_gnt_addr", bus.ram_addr, 16'h0030);
        @(posedge CLK); #1;
        bus.d_ren = 1'b0;
        @(negedge CLK);
        chk("abort_ren_drop", bus.ram_ren, 1'b0);
        chk("abort_d_busy", bus.d_busy, 1'b1);
        dz = 0; ic = 0; ti = 0; ig = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!bus.d_busy) dz++;
            if (!bus.i_busy) begin ic++; ti = cyc; ig = bus.i_rdata; break; end
        end
        chk("abort_d_never_done", dz, 0);
        chk("abort_i_done", ic, 1);
        chk("abort_i_cycle", ti - t0, 7);
        chk("abort_i_rdata", ig, ref_mem[8'h31]);
        m_last_d = 1'b0;
        @(posedge CLK); #1;
        clear_reqs();

        // Reset during a D write, LAT=3
        @(posedge CLK); #1;
        bus.d_addr = 16'h0040; bus.d_wdata = 32'h12345678; bus.d_byte_en = 4'hF;
        bus.d_wen = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_gnt_wen", bus.ram_wen, 1'b1);
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        chk("rst_ram_wen", bus.ram_wen, 1'b0);
        chk("rst_ram_addr", bus.ram_addr, 16'h0);
        chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
        chk("rst_d_busy", bus.d_busy, 1'b1);
        chk("rst_i_busy", bus.i_busy, 1'b1);
        clear_reqs();
        @(posedge CLK); #1;
        nRST = 1'b1;
        m_last_d = 1'b0;
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00, 32'h0, 4'h0, 3);
        chk("rst_no_write", last_i_rdata, 32'h55AA55AA);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            op = $urandom_range(1, 3);
            ui = op[0];
            ud = op[1];
            op = $urandom_range(0, 2);
            dr = (op != 1);
            dw = (op != 0);
            run_round(ui, ud, dw, dr, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
